// File: rtl/cash_dispenser_if.sv
// Request, note-ejection and status bundle between the ATM controller and the
// cash dispenser. The slave side is the dispenser.
interface cash_dispenser_if;
    logic        req_valid;
    logic [10:0] req_amount;
    logic        req_ready;
    logic        refill;
    logic        note_valid;
    logic [1:0]  note_type;
    logic        note_ack;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [7:0]  cnt_hi;
    logic [7:0]  cnt_mid;
    logic [7:0]  cnt_lo;

    modport slave (
        input  req_valid, req_amount, refill, note_ack,
        output req_ready, note_valid, note_type, done, error, err_code,
               cnt_hi, cnt_mid, cnt_lo
    );

    modport master (
        output req_valid, req_amount, refill, note_ack,
        input  req_ready, note_valid, note_type, done, error, err_code,
               cnt_hi, cnt_mid, cnt_lo
    );
endinterface

// File: rtl/cash_dispenser.sv
// Splits an approved withdrawal into HI/MID/LO notes with a greedy plan bounded
// by cassette stock, then ejects them one at a time over a valid/ack handshake.
module cash_dispenser #(
    parameter int DENOM_HI   = 200,
    parameter int DENOM_MID  = 100,
    parameter int DENOM_LO   = 50,
    parameter int INIT_NOTES = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    cash_dispenser_if.slave   bus
);

    localparam logic [10:0] D_HI  = 11'(DENOM_HI);
    localparam logic [10:0] D_MID = 11'(DENOM_MID);
    localparam logic [10:0] D_LO  = 11'(DENOM_LO);
    localparam logic [7:0]  INIT  = 8'(INIT_NOTES);

    localparam logic [1:0] T_HI  = 2'b00;
    localparam logic [1:0] T_MID = 2'b01;
    localparam logic [1:0] T_LO  = 2'b10;

    localparam logic [1:0] E_BAD_AMOUNT = 2'b01;
    localparam logic [1:0] E_NO_NOTES   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        DISPENSE,
        DONE,
        ERR
    } state_t;

    state_t      state, state_n;
    logic [10:0] rem, rem_n;
    logic [5:0]  plan_hi, plan_hi_n;
    logic [5:0]  plan_mid, plan_mid_n;
    logic [5:0]  plan_lo, plan_lo_n;
    logic [7:0]  cnt_hi, cnt_hi_n;
    logic [7:0]  cnt_mid, cnt_mid_n;
    logic [7:0]  cnt_lo, cnt_lo_n;
    logic [1:0]  err_code_q, err_code_n;
    logic [1:0]  cur_type;
    logic [7:0]  plan_total;

    // Notes leave in HI, MID, LO order, so the current note is the highest
    // denomination with notes still planned.
    always_comb begin
        if (plan_hi != 6'd0)       cur_type = T_HI;
        else if (plan_mid != 6'd0) cur_type = T_MID;
        else                       cur_type = T_LO;
    end

    assign plan_total = {2'b00, plan_hi} + {2'b00, plan_mid} + {2'b00, plan_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem        <= '0;
            plan_hi    <= '0;
            plan_mid   <= '0;
            plan_lo    <= '0;
            cnt_hi     <= INIT;
            cnt_mid    <= INIT;
            cnt_lo     <= INIT;
            err_code_q <= '0;
        end else begin
            rem        <= rem_n;
            plan_hi    <= plan_hi_n;
            plan_mid   <= plan_mid_n;
            plan_lo    <= plan_lo_n;
            cnt_hi     <= cnt_hi_n;
            cnt_mid    <= cnt_mid_n;
            cnt_lo     <= cnt_lo_n;
            err_code_q <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        rem_n      = rem;
        plan_hi_n  = plan_hi;
        plan_mid_n = plan_mid;
        plan_lo_n  = plan_lo;
        cnt_hi_n   = cnt_hi;
        cnt_mid_n  = cnt_mid;
        cnt_lo_n   = cnt_lo;
        err_code_n = err_code_q;

        unique case (state)
            IDLE: begin
                // Refill wins over a simultaneous request; req_ready is low.
                if (bus.refill) begin
                    cnt_hi_n  = INIT;
                    cnt_mid_n = INIT;
                    cnt_lo_n  = INIT;
                end else if (bus.req_valid) begin
                    if (bus.req_amount == 11'd0) begin
                        err_code_n = E_BAD_AMOUNT;
                        state_n    = ERR;
                    end else begin
                        rem_n      = bus.req_amount;
                        plan_hi_n  = '0;
                        plan_mid_n = '0;
                        plan_lo_n  = '0;
                        state_n    = PLAN;
                    end
                end
            end

            // One greedy decision per cycle; cassettes are untouched until
            // notes are actually taken, so a rejection needs no rollback.
            PLAN: begin
                if (rem >= D_HI && {2'b00, plan_hi} < cnt_hi) begin
                    rem_n     = rem - D_HI;
                    plan_hi_n = plan_hi + 6'd1;
                end else if (rem >= D_MID && {2'b00, plan_mid} < cnt_mid) begin
                    rem_n      = rem - D_MID;
                    plan_mid_n = plan_mid + 6'd1;
                end else if (rem >= D_LO && {2'b00, plan_lo} < cnt_lo) begin
                    rem_n     = rem - D_LO;
                    plan_lo_n = plan_lo + 6'd1;
                end else if (rem == 11'd0) begin
                    state_n = DISPENSE;
                end else if (rem < D_LO) begin
                    err_code_n = E_BAD_AMOUNT;
                    state_n    = ERR;
                end else begin
                    err_code_n = E_NO_NOTES;
                    state_n    = ERR;
                end
            end

            DISPENSE: begin
                if (bus.note_ack) begin
                    unique case (cur_type)
                        T_HI: begin
                            plan_hi_n = plan_hi - 6'd1;
                            cnt_hi_n  = cnt_hi - 8'd1;
                        end
                        T_MID: begin
                            plan_mid_n = plan_mid - 6'd1;
                            cnt_mid_n  = cnt_mid - 8'd1;
                        end
                        default: begin
                            plan_lo_n = plan_lo - 6'd1;
                            cnt_lo_n  = cnt_lo - 8'd1;
                        end
                    endcase
                    if (plan_total == 8'd1) state_n = DONE;
                end
            end

            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE) && !bus.refill;
    assign bus.note_valid = (state == DISPENSE);
    assign bus.note_type  = cur_type;
    assign bus.done       = (state == DONE);
    assign bus.error      = (state == ERR);
    assign bus.err_code   = err_code_q;
    assign bus.cnt_hi     = cnt_hi;
    assign bus.cnt_mid    = cnt_mid;
    assign bus.cnt_lo     = cnt_lo;

endmodule

// File: doc/cash_dispenser.md
Name: cash_dispenser

Overview:
- Downstream stage of the ATM transaction FSM.
- Once a withdrawal has been approved and debited, the ATM hands the amount to this block.
- The block splits the amount into banknotes using a greedy, availability-limited plan. It then drives a note-ejection mechanism one note at a time over a valid/ack handshake and tracks how many notes remain in each of three cassettes.

Parameters:
- DENOM_HI, 200, value of the high denomination note (type 2'b00)
- DENOM_MID, 100, value of the middle denomination note (type 2'b01)
- DENOM_LO, 50, value of the low denomination note (type 2'b10); also the granularity of valid amounts
- INIT_NOTES, 20, notes loaded in each cassette at reset and on refill (must be ≤ 255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  withdrawal request present
- req_amount  in  11  amount to dispense, sampled when req_valid & req_ready
- req_ready  out  1  block can accept a request: (state==IDLE) & ~refill
- refill  in  1  reload all cassettes to INIT_NOTES; honoured in IDLE only
- note_valid  out  1  a note is being ejected
- note_type  out  2  denomination of the current note: 00 HI, 01 MID, 10 LO
- note_ack  in  1  mechanism has taken the current note
- done  out  1  one-cycle pulse: all planned notes dispensed
- error  out  1  one-cycle pulse: request rejected, nothing dispensed
- err_code  out  2  valid with error: 01 bad amount, 10 insufficient notes; holds last value
- cnt_hi, cnt_mid, cnt_lo  out  8 each  notes remaining per cassette

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - note_valid=0, done=0, error=0, err_code=00
  - cnt_*=INIT_NOTES
  - internal remainder and plan counters (6 bits each) cleared
  - An abort mid-dispense loses the in-flight request; notes already acked stay deducted only until the reset reloads the counts.
- States: IDLE, PLAN, DISPENSE, DONE, ERR.
- IDLE:
  - refill=1 → cnt_* loaded with INIT_NOTES next edge. Refill has priority over a simultaneous request, which is not accepted (req_ready=0).
  - Refill outside IDLE is ignored.
  - req_valid & req_ready, req_amount==0 → ERR with code 01.
  - req_valid & req_ready, nonzero amount → rem=req_amount, plan_*=0, go to PLAN.
  - req_valid while not ready is ignored; it is not queued.
- PLAN, one decision per cycle, in priority order:
  - rem≥DENOM_HI and plan_hi<cnt_hi → rem-=DENOM_HI, plan_hi++
  - else rem≥DENOM_MID and plan_mid<cnt_mid → rem-=DENOM_MID, plan_mid++
  - else rem≥DENOM_LO and plan_lo<cnt_lo → rem-=DENOM_LO, plan_lo++
  - else rem==0 → DISPENSE
  - else rem<DENOM_LO → ERR, code 01 (amount not a multiple of DENOM_LO)
  - else → ERR, code 10 (cassettes cannot cover the amount)
  - Plan latency is N+1 cycles for N notes. No cassette is touched during PLAN, so a rejected request leaves cnt_* unchanged.
- DISPENSE:
  - Present notes in order: all HI, then all MID, then all LO.
  - note_valid=1 with note_type stable until the cycle in which note_ack=1.
  - On ack: decrement the matching plan_* and cnt_*. The next note (if any) is presented on the following cycle, with back-to-back valid permitted.
  - When the last plan counter reaches 0 on an ack, go to DONE.
  - note_ack while note_valid=0 is ignored.
  - There is no timeout; the block waits indefinitely for ack.
- DONE: done=1 for one cycle → IDLE.
- ERR: error=1 for one cycle, err_code updated → IDLE.
- Arithmetic:
  - rem is 11-bit unsigned and never underflows, because subtraction is guarded by compare.
  - Plan counters are 6 bits (max 2047/50 = 40 notes).
  - cnt_* never decrements below 0, because the plan is bounded by cnt_*.
- Greedy is the defined algorithm. A request that a non-greedy split could satisfy but greedy cannot is rejected with code 10.

Test Plan:
- Reset released, default parameters → cnt_hi/mid/lo=20/20/20, req_ready=1, note_valid=0, done=0, error=0.
- req_amount=350, note_ack tied high → notes 00, 01, 10 on consecutive cycles; done pulses once; cnt=19/19/19.
- req_amount=75 → one PLAN step (HI/MID skipped, LO taken, rem=25), then error=1, err_code=01; no note_valid; cnt unchanged. req_amount=0 → error, err_code=01 the cycle after accept.
- INIT_NOTES=1, req_amount=500 → plan 200+100+50 leaves rem=150, then error=1, err_code=10; cnt=1/1/1. Same instance, req_amount=350 → dispensed, cnt=0/0/0.
- req_amount=400, note_ack held low 5 cycles on the first note → note_valid=1, note_type=00 stable throughout; ack → second 00, done; cnt_hi=18. Repeat with rst_n pulsed low mid-dispense → note_valid drops immediately, state IDLE, cnt=20/20/20.
- After dispensing 1000 (cnt_hi=15), assert refill together with req_valid in IDLE → req_ready=0, request not taken, cnt_hi=20 next cycle; refill during DISPENSE → no effect on cnt_*.
